rf_write_arbiter: RTL and testbench

- Owns the single register-file write port (we3/wa3/wd3) and shares it between two requesters: requester 0 (core writeback) and requester 1 (debug/loader).
- After reset, sequences a clear of registers 1..31 before any requester is served.
- Valid/ready handshake per requester. Round-robin or fixed-priority arbitration.
- Sits between the datapath writeback mux and the register file.

---
 rtl/rf_write_arbiter.sv | 105 ++++++++++
 tb/tb_rf_write_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: clears registers 1..31 after reset, then
// arbitrates the single write port between core writeback (0) and debug/loader (1).
module rf_write_arbiter #(
  parameter int          INIT_EN    = 1,
  parameter logic [31:0] INIT_VALUE = 32'h0,
  parameter int          ARB_MODE   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        init_busy,
  output logic        dbg_state
);

  // Handshake: a write transfers on a rising edge where reqN_valid && reqN_ready;
  // ready depends only on the valids and registered state, never on itself.
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        gnt0, gnt1;
  logic        we_c, busy_c;
  logic [4:0]  wa_c;
  logic [31:0] wd_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= 5'd1;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    we_c    = 1'b0;
    wa_c    = 5'd0;
    wd_c    = 32'd0;
    busy_c  = 1'b0;
    case (state_q)
      ST_INIT: begin
        we_c   = 1'b1;
        wa_c   = cnt_q;
        wd_c   = INIT_VALUE;
        busy_c = 1'b1;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_RUN;
          cnt_d   = 5'd1;
        end
      end
      ST_RUN: begin
        // ptr_q holds the last granted index; the other one wins a tie.
        if (req0_valid && req1_valid) begin
          if ((ARB_MODE != 0) || ptr_q) gnt0 = 1'b1;
          else                          gnt1 = 1'b1;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
        if (gnt0) begin
          wa_c  = req0_addr;
          wd_c  = req0_data;
          we_c  = (req0_addr != 5'd0);
          ptr_d = 1'b0;
        end else if (gnt1) begin
          wa_c  = req1_addr;
          wd_c  = req1_data;
          we_c  = (req1_addr != 5'd0);
          ptr_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of state.
  assign req0_ready = gnt0 & reset;
  assign req1_ready = gnt1 & reset;
  assign we3        = we_c & reset;
  assign wa3        = reset ? wa_c : 5'd0;
  assign wd3        = reset ? wd_c : 32'd0;
  assign init_busy  = reset ? busy_c : (INIT_EN != 0);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: round-robin and fixed-priority instances
// driven in parallel, with a register-file model behind the round-robin one.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;

  logic        r0_a, r1_a, we_a, busy_a, st_a;
  logic [4:0]  wa_a;
  logic [31:0] wd_a;
  logic        r0_b, r1_b, we_b, busy_b, st_b;
  logic [4:0]  wa_b;
  logic [31:0] wd_b;

  logic [31:0] rf [32];
  logic [39:0] exp_q0[$];
  logic [39:0] exp_q1[$];
  bit          ptr_m0, ptr_m1;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.INIT_EN(1), .INIT_VALUE(32'hDEADBEEF), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(r0_a),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(r1_a),
    .we3(we_a), .wa3(wa_a), .wd3(wd_a), .init_busy(busy_a), .dbg_state(st_a));

  rf_write_arbiter #(.INIT_EN(1), .INIT_VALUE(32'hDEADBEEF), .ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(r0_b),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(r1_b),
    .we3(we_b), .wa3(wa_b), .wd3(wd_b), .init_busy(busy_b), .dbg_state(st_b));

  initial for (int i = 0; i < 32; i++) rf[i] = 32'd0;
  always @(posedge clk) if (we_a) rf[wa_a] <= wd_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected port image {ready0, ready1, we3, wa3, wd3} for one RUN cycle.
  task automatic predict(input bit fixed_pri, input bit ptr,
                         input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                         output logic [39:0] e, output bit nptr);
    bit pick0, pick1;
    pick0 = v0 && (!v1 || fixed_pri || ptr == 1'b1);
    pick1 = v1 && !pick0;
    nptr  = ptr;
    e     = 40'd0;
    if (pick0) begin
      e = {1'b1, 1'b0, a0 != 5'd0, a0, d0};
      nptr = 1'b0;
    end else if (pick1) begin
      e = {1'b0, 1'b1, a1 != 5'd0, a1, d1};
      nptr = 1'b1;
    end
  endtask

  // Drive one RUN cycle at a negedge and queue what each instance should show.
  task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    logic [39:0] e;
    bit np;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    predict(1'b0, ptr_m0, v0, a0, d0, v1, a1, d1, e, np);
    exp_q0.push_back(e);
    ptr_m0 = np;
    predict(1'b1, ptr_m1, v0, a0, d0, v1, a1, d1, e, np);
    exp_q1.push_back(e);
    ptr_m1 = np;
  endtask

  task automatic compare_sb();
    logic [39:0] e;
    if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
      check("sb_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd2);
    end else begin
      e = exp_q0.pop_front();
      check("rr_port", {24'd0, r0_a, r1_a, we_a, wa_a, wd_a}, {24'd0, e});
      e = exp_q1.pop_front();
      check("fp_port", {24'd0, r0_b, r1_b, we_b, wa_b, wd_b}, {24'd0, e});
    end
    check("ready_excl", {62'd0, r0_a & r1_a, r0_b & r1_b}, 64'd0);
    check("run_busy", {62'd0, busy_a, busy_b}, 64'd0);
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
  endtask

  // Entered at the negedge where reset was released; checks n INIT cycles.
  task automatic init_seq(input int n);
    for (int i = 1; i <= n; i++) begin
      #1;
      check("init_busy", {62'd0, busy_a, busy_b}, 64'h3);
      check("init_wa3", {54'd0, we_a, wa_a, we_b, wa_b}, {54'd0, 1'b1, 5'(i), 1'b1, 5'(i)});
      check("init_wd3", {wd_a, wd_b}, {32'hDEADBEEF, 32'hDEADBEEF});
      check("init_ready", {60'd0, r0_a, r1_a, r0_b, r1_b}, 64'd0);
      if (i < n) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {r0_a, r1_a, we_a, wa_a, wd_a, r0_b, r1_b, we_b, wa_b, wd_b}, 64'd0);
    check("reset_busy", {62'd0, busy_a, busy_b}, 64'h3);
  endtask

  initial begin
    reset  = 1'b0;
    ptr_m0 = 1'b1;
    ptr_m1 = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset_out");

    // Full clear sequence.
    @(negedge clk);
    reset = 1'b1;
    init_seq(31);
    @(negedge clk);
    #1;
    check("busy_done", {62'd0, busy_a, busy_b}, 64'd0);
    check("state_run", {62'd0, st_a, st_b}, 64'h3);
    check("rf0_zero", {32'd0, rf[0]}, 64'd0);
    for (int r = 1; r < 32; r++) check("rf_cleared", {32'd0, rf[r]}, {32'd0, 32'hDEADBEEF});

    // Contention straight after INIT: round-robin alternates starting with 0,
    // fixed priority always picks 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd6, 32'hA0A0_0000 + 32'(i), 1'b1, 5'd7, 32'hB0B0_0000 + 32'(i));
      #1 compare_sb();
      check("rr_alt", {62'd0, r0_a, r1_a}, (i % 2 == 0) ? 64'h2 : 64'h1);
      if (i < 3) check("fp_pri", {62'd0, r0_b, r1_b}, 64'h2);
    end

    // Single requester 0, readback on the following cycle.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd9, 32'h9999);
    #1 compare_sb();
    check("req0_only", {57'd0, r0_a, we_a, wa_a}, {57'd0, 1'b1, 1'b1, 5'd5});
    @(negedge clk);
    check("rf5_write", {32'd0, rf[5]}, 64'h1234);
    check("rf7_write", {32'd0, rf[7]}, 64'hB0B0_0003);

    // Write to register 0 is accepted but dropped; pointer still moves.
    drive(1'b0, 5'd3, 32'h3, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1 compare_sb();
    check("addr0_drop", {62'd0, r1_a, we_a}, 64'h2);
    @(negedge clk);
    check("rf0_kept", {32'd0, rf[0]}, 64'd0);
    drive(1'b1, 5'd8, 32'h8888, 1'b1, 5'd9, 32'h9999);
    #1 compare_sb();
    check("after_addr0", {62'd0, r0_a, r1_a}, 64'h2);

    // Idle cycle and a short random mix.
    @(negedge clk);
    drive(1'b0, 5'd1, 32'h1, 1'b0, 5'd2, 32'h2);
    #1 compare_sb();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      #1 compare_sb();
    end

    // Reset during INIT at counter 10, then a full restart.
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1 check_reset_outputs("mid_run_reset");
    @(negedge clk);
    reset = 1'b1;
    ptr_m0 = 1'b1;
    ptr_m1 = 1'b1;
    init_seq(10);
    #1 reset = 1'b0;
    #1 check_reset_outputs("mid_init_reset");
    @(negedge clk);
    reset = 1'b1;
    init_seq(31);
    @(negedge clk);
    #1;
    check("busy_done2", {62'd0, busy_a, busy_b}, 64'd0);
    check("rf5_recleared", {32'd0, rf[5]}, {32'd0, 32'hDEADBEEF});
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33);
    #1 compare_sb();
    check("ptr_reset", {62'd0, r0_a, r1_a}, 64'h2);

    check("sb_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
